// File: rtl/i2cmb_cmd_sequencer.sv
// i2cmb_cmd_sequencer
//   Wishbone master that runs one iicmb_m_wb controller without software. It takes
//   single-byte I2C transfer requests and walks the controller through the full
//   CSR/DPR/CMDR sequence (enable, set bus, start, address, data write or read, stop),
//   then returns the read byte and a completion status.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake (ready only while idle)
//   req_rw_i                  0 = write byte, 1 = read byte (read-with-NAK)
//   req_bus_i/addr_i/data_i   target bus id, 7-bit slave address, write data
//   rsp_valid_o               one-cycle completion pulse
//   rsp_data_o                read data (0x00 on writes or errors), held until next response
//   rsp_status_o              00 ok, 01 NAK, 10 arbitration lost, 11 error or timeout
//   cyc_o, stb_o, we_o        Wishbone cycle/strobe (always equal) and write enable
//   adr_o, dat_o, dat_i       Wishbone address (0 CSR, 1 DPR, 2 CMDR), write/read data
//   ack_i                     Wishbone acknowledge
//   irq_i                     controller interrupt, only looked at while waiting on a command
//
// States
//   S_ENABLE    | write CSR = E|IE once after reset
//   S_IDLE      | req_ready_o high, waiting for a request
//   S_BUS_DPR   | DPR <= bus id
//   S_BUS_CMD   | CMDR <= set bus
//   S_START_CMD | CMDR <= start
//   S_ADDR_DPR  | DPR <= {addr, rw}
//   S_ADDR_CMD  | CMDR <= write (address byte)
//   S_DATA_DPR  | DPR <= write data
//   S_DATA_CMD  | CMDR <= write (data byte)
//   S_RD_CMD    | CMDR <= read with NAK
//   S_RD_DPR    | Wishbone read of DPR into the read-data register
//   S_STOP_CMD  | CMDR <= stop
//   S_WAIT      | wait for irq_i, bounded by IRQ_TIMEOUT
//   S_STATUS    | Wishbone read of CMDR (clears irq) and decode of completion bits
//   S_RESPOND   | rsp_valid_o pulse

module i2cmb_cmd_sequencer #(
   parameter int NUM_BUSSES  = 16,
   parameter int IRQ_TIMEOUT = 65535,
   localparam int BUS_W = (NUM_BUSSES > 1) ? $clog2(NUM_BUSSES) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_rw_i,
   input  logic [BUS_W-1:0] req_bus_i,
   input  logic [6:0]       req_addr_i,
   input  logic [7:0]       req_data_i,
   output logic             rsp_valid_o,
   output logic [7:0]       rsp_data_o,
   output logic [1:0]       rsp_status_o,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic [1:0]       adr_o,
   output logic [7:0]       dat_o,
   input  logic [7:0]       dat_i,
   input  logic             ack_i,
   input  logic             irq_i
);

   localparam int CNT_W = (IRQ_TIMEOUT > 0) ? $clog2(IRQ_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(IRQ_TIMEOUT);
   localparam bit TO_EN = (IRQ_TIMEOUT != 0);

   localparam logic [1:0] ADR_CSR  = 2'd0;
   localparam logic [1:0] ADR_DPR  = 2'd1;
   localparam logic [1:0] ADR_CMDR = 2'd2;

   localparam logic [7:0] CSR_EN       = 8'hC0;
   localparam logic [7:0] CMD_WRITE    = 8'h01;
   localparam logic [7:0] CMD_READ_NAK = 8'h03;
   localparam logic [7:0] CMD_START    = 8'h04;
   localparam logic [7:0] CMD_STOP     = 8'h05;
   localparam logic [7:0] CMD_SET_BUS  = 8'h06;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_NAK = 2'b01;
   localparam logic [1:0] ST_AL  = 2'b10;
   localparam logic [1:0] ST_ERR = 2'b11;

   typedef enum logic [3:0] {
      S_ENABLE, S_IDLE, S_BUS_DPR, S_BUS_CMD, S_START_CMD, S_ADDR_DPR, S_ADDR_CMD,
      S_DATA_DPR, S_DATA_CMD, S_RD_CMD, S_RD_DPR, S_STOP_CMD, S_WAIT, S_STATUS, S_RESPOND
   } state_t;

   state_t           state_q, state_d;
   state_t           after_wait_q, after_wait_d;
   logic             cyc_q, cyc_d;
   logic             we_q, we_d;
   logic [1:0]       adr_q, adr_d;
   logic [7:0]       dat_q, dat_d;
   logic             ready_q, ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic [1:0]       rsp_status_q, rsp_status_d;
   logic [1:0]       status_q, status_d;
   logic             rw_q, rw_d;
   logic [BUS_W-1:0] bus_q, bus_d;
   logic [6:0]       addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             acc_done;
   logic             acc_en;
   logic             acc_we;
   logic [1:0]       acc_adr;
   logic [7:0]       acc_dat;
   logic             cmd_wr;
   state_t           wait_next;
   logic             fin;
   logic [1:0]       fin_status;

   // cyc_q is only ever high inside an access state, so this marks the last cycle of it
   assign acc_done = cyc_q & ack_i;

   always_comb begin
      state_d      = state_q;
      after_wait_d = after_wait_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      ready_d      = ready_q;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      status_d     = status_q;
      rw_d         = rw_q;
      bus_d        = bus_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rd_data_d    = rd_data_q;
      cnt_d        = cnt_q;
      acc_en       = 1'b0;
      acc_we       = 1'b1;
      acc_adr      = ADR_CMDR;
      acc_dat      = 8'h00;
      cmd_wr       = 1'b0;
      wait_next    = S_IDLE;
      fin          = 1'b0;
      fin_status   = status_q;

      case (state_q)
         S_ENABLE: begin
            acc_en  = 1'b1;
            acc_adr = ADR_CSR;
            acc_dat = CSR_EN;
            if (acc_done) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
            end
         end
         S_IDLE: begin
            if (req_valid_i && ready_q) begin
               ready_d   = 1'b0;
               rw_d      = req_rw_i;
               bus_d     = req_bus_i;
               addr_d    = req_addr_i;
               wdata_d   = req_data_i;
               status_d  = ST_OK;
               rd_data_d = 8'h00;
               state_d   = S_BUS_DPR;
            end
         end
         S_BUS_DPR: begin
            acc_en  = 1'b1;
            acc_adr = ADR_DPR;
            acc_dat = 8'(bus_q);
            if (acc_done) state_d = S_BUS_CMD;
         end
         S_BUS_CMD: begin
            acc_en    = 1'b1;
            acc_dat   = CMD_SET_BUS;
            cmd_wr    = 1'b1;
            wait_next = S_START_CMD;
         end
         S_START_CMD: begin
            acc_en    = 1'b1;
            acc_dat   = CMD_START;
            cmd_wr    = 1'b1;
            wait_next = S_ADDR_DPR;
         end
         S_ADDR_DPR: begin
            acc_en  = 1'b1;
            acc_adr = ADR_DPR;
            acc_dat = {addr_q, rw_q};
            if (acc_done) state_d = S_ADDR_CMD;
         end
         S_ADDR_CMD: begin
            acc_en    = 1'b1;
            acc_dat   = CMD_WRITE;
            cmd_wr    = 1'b1;
            wait_next = rw_q ? S_RD_CMD : S_DATA_DPR;
         end
         S_DATA_DPR: begin
            acc_en  = 1'b1;
            acc_adr = ADR_DPR;
            acc_dat = wdata_q;
            if (acc_done) state_d = S_DATA_CMD;
         end
         S_DATA_CMD: begin
            acc_en    = 1'b1;
            acc_dat   = CMD_WRITE;
            cmd_wr    = 1'b1;
            wait_next = S_STOP_CMD;
         end
         S_RD_CMD: begin
            acc_en    = 1'b1;
            acc_dat   = CMD_READ_NAK;
            cmd_wr    = 1'b1;
            wait_next = S_RD_DPR;
         end
         S_RD_DPR: begin
            acc_en  = 1'b1;
            acc_we  = 1'b0;
            acc_adr = ADR_DPR;
            if (acc_done) begin
               rd_data_d = dat_i;
               state_d   = S_STOP_CMD;
            end
         end
         S_STOP_CMD: begin
            acc_en    = 1'b1;
            acc_dat   = CMD_STOP;
            cmd_wr    = 1'b1;
            wait_next = S_RESPOND;
         end
         S_WAIT: begin
            if (irq_i) begin
               state_d = S_STATUS;
            end else if (TO_EN && (cnt_q == TO_VAL)) begin
               fin        = 1'b1;
               fin_status = ST_ERR;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STATUS: begin
            acc_en = 1'b1;
            acc_we = 1'b0;
            // after_wait_q == S_RESPOND identifies the stop command
            if (acc_done) begin
               if (dat_i[7]) begin
                  if (after_wait_q == S_RESPOND) fin = 1'b1;
                  else state_d = after_wait_q;
               end else if (dat_i[4]) begin
                  fin        = 1'b1;
                  fin_status = ST_ERR;
               end else if (dat_i[5]) begin
                  fin        = 1'b1;
                  fin_status = ST_AL;
               end else if (dat_i[6]) begin
                  if (after_wait_q == S_RESPOND) begin
                     fin = 1'b1;
                  end else begin
                     status_d = ST_NAK;
                     state_d  = S_STOP_CMD;
                  end
               end else begin
                  // interrupt without any completion bit: treat as controller error
                  fin        = 1'b1;
                  fin_status = ST_ERR;
               end
            end
         end
         S_RESPOND: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: state_d = S_ENABLE;
      endcase

      if (acc_en && !cyc_q) begin
         cyc_d = 1'b1;
         we_d  = acc_we;
         adr_d = acc_adr;
         dat_d = acc_dat;
      end
      // dropping cyc for a cycle after every ack guarantees the idle gap between accesses
      if (acc_done) cyc_d = 1'b0;

      if (acc_done && cmd_wr) begin
         state_d      = S_WAIT;
         after_wait_d = wait_next;
         cnt_d        = '0;
      end

      if (fin) begin
         state_d      = S_RESPOND;
         rsp_valid_d  = 1'b1;
         rsp_status_d = fin_status;
         rsp_data_d   = ((fin_status == ST_OK) && rw_q) ? rd_data_q : 8'h00;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_ENABLE;
         after_wait_q <= S_IDLE;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= 2'd0;
         dat_q        <= 8'h00;
         ready_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 8'h00;
         rsp_status_q <= 2'b00;
         status_q     <= 2'b00;
         rw_q         <= 1'b0;
         bus_q        <= '0;
         addr_q       <= 7'h00;
         wdata_q      <= 8'h00;
         rd_data_q    <= 8'h00;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         after_wait_q <= after_wait_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         ready_q      <= ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         status_q     <= status_d;
         rw_q         <= rw_d;
         bus_q        <= bus_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rd_data_q    <= rd_data_d;
         cnt_q        <= cnt_d;
      end
   end

   assign req_ready_o  = ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_status_o = rsp_status_q;
   assign cyc_o        = cyc_q;
   assign stb_o        = cyc_q;
   assign we_o         = we_q;
   assign adr_o        = adr_q;
   assign dat_o        = dat_q;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Bench for i2cmb_cmd_sequencer. A behavioural iicmb controller answers the Wishbone
// accesses; expected Wishbone writes and expected responses are queued by the stimulus
// and popped/compared by the controller model and a response monitor.
module tb_i2cmb_cmd_sequencer;

   localparam int NB = 12;
   localparam int TO = 100;

   logic       clk_i, rst_i;
   logic       req_valid_i, req_ready_o, req_rw_i;
   logic [3:0] req_bus_i;
   logic [6:0] req_addr_i;
   logic [7:0] req_data_i;
   logic       rsp_valid_o;
   logic [7:0] rsp_data_o;
   logic [1:0] rsp_status_o;
   logic       cyc_o, stb_o, we_o;
   logic [1:0] adr_o;
   logic [7:0] dat_o, dat_i;
   logic       ack_i, irq_i;

   i2cmb_cmd_sequencer #(.NUM_BUSSES(NB), .IRQ_TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
      .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
   );

   int total = 0;
   int bad = 0;
   int cyc_cnt = 0;
   logic [9:0] exp_wb[$];   // {adr, dat}
   logic [9:0] exp_rsp[$];  // {status, data}
   bit irq_kill = 0;
   bit force_al = 0;
   int data_cmd_cnt = 0;
   int last_cmdr_cyc = 0;
   logic [7:0] dpr_reg;
   logic [7:0] cmd_sts;
   bit addr_phase;
   int irq_delay;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial forever begin
      @(posedge clk_i);
      cyc_cnt++;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_w(logic [1:0] adr, logic [7:0] dat);
      exp_wb.push_back({adr, dat});
   endtask

   task automatic exp_r(logic [1:0] st, logic [7:0] dat);
      exp_rsp.push_back({st, dat});
   endtask

   task automatic send(bit rw, logic [3:0] bus, logic [6:0] addr, logic [7:0] data);
      int n = 0;
      while (!req_ready_o && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      if (!req_ready_o) begin
         total++;
         bad++;
         $display("FAIL req_ready: not ready after %0d cycles", n);
      end
      req_rw_i    = rw;
      req_bus_i   = bus;
      req_addr_i  = addr;
      req_data_i  = data;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      check("ready_drop", 32'(req_ready_o), 32'd0);
      req_valid_i = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while ((exp_rsp.size() != 0 || exp_wb.size() != 0 || !req_ready_o) && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 2000) begin
         total++;
         bad++;
         $display("FAIL %s: timeout, pending wb=%0d rsp=%0d", name, exp_wb.size(), exp_rsp.size());
         exp_wb.delete();
         exp_rsp.delete();
      end
      repeat (2) @(negedge clk_i);
   endtask

   // behavioural iicmb controller: acks one cycle after cyc, raises irq 3 cycles after a CMDR write
   initial begin
      ack_i = 1'b0; irq_i = 1'b0; dat_i = 8'h00;
      dpr_reg = 8'h00; cmd_sts = 8'h00; addr_phase = 1'b0; irq_delay = -1;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            ack_i = 1'b0; irq_i = 1'b0; irq_delay = -1; addr_phase = 1'b0;
         end else begin
            if (irq_delay > 0) irq_delay--;
            else if (irq_delay == 0) begin
               irq_i = 1'b1;
               irq_delay = -1;
            end
            if (ack_i) ack_i = 1'b0;
            else if (cyc_o) begin
               ack_i = 1'b1;
               if (we_o) begin
                  if (exp_wb.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL wb_write: unexpected adr=%0d dat=%02h", adr_o, dat_o);
                  end else begin
                     check("wb_write", {22'd0, adr_o, dat_o}, {22'd0, exp_wb.pop_front()});
                  end
                  case (adr_o)
                     2'd1: dpr_reg = dat_o;
                     2'd2: begin
                        last_cmdr_cyc = cyc_cnt;
                        case (dat_o)
                           8'h06: cmd_sts = (dpr_reg >= 8'(NB)) ? 8'h10 : 8'h80;
                           8'h04: begin
                              cmd_sts = force_al ? 8'h20 : 8'h80;
                              addr_phase = 1'b1;
                           end
                           8'h01: begin
                              if (addr_phase) cmd_sts = (dpr_reg[7:1] == 7'h22) ? 8'h80 : 8'h40;
                              else begin
                                 cmd_sts = 8'h80;
                                 data_cmd_cnt++;
                              end
                              addr_phase = 1'b0;
                           end
                           8'h03: begin
                              cmd_sts = 8'h80;
                              dpr_reg = 8'h3C;
                           end
                           default: cmd_sts = 8'h80;
                        endcase
                        if (!irq_kill) irq_delay = 3;
                     end
                     default: ;
                  endcase
               end else begin
                  case (adr_o)
                     2'd1: dat_i = dpr_reg;
                     2'd2: begin
                        dat_i = cmd_sts;
                        irq_i = 1'b0;
                     end
                     default: dat_i = 8'h00;
                  endcase
               end
            end
         end
      end
   end

   // response monitor
   initial forever begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
         if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp: unexpected response status=%0d data=%02h", rsp_status_o, rsp_data_o);
         end else begin
            check("rsp", {22'd0, rsp_status_o, rsp_data_o}, {22'd0, exp_rsp.pop_front()});
         end
         @(negedge clk_i);
         check("rsp_pulse", 32'(rsp_valid_o), 32'd0);
      end
   end

   // Wishbone protocol: stb follows cyc, and cyc drops the cycle after an ack
   initial forever begin
      @(posedge clk_i);
      #2;
      if (!rst_i) begin
         if (cyc_o || stb_o) check("cyc_stb", 32'(stb_o), 32'(cyc_o));
         if (ack_i) check("wb_gap", 32'(cyc_o), 32'd0);
      end
   end

   initial begin
      int n;
      int diff;
      int base;
      rst_i = 1'b1; req_valid_i = 1'b0; req_rw_i = 1'b0;
      req_bus_i = 4'd0; req_addr_i = 7'h00; req_data_i = 8'h00;
      repeat (3) @(negedge clk_i);
      check("rst_ready", 32'(req_ready_o), 32'd0);
      check("rst_cyc", 32'(cyc_o), 32'd0);
      check("rst_stb", 32'(stb_o), 32'd0);
      check("rst_we", 32'(we_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_status", 32'(rsp_status_o), 32'd0);
      check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
      check("rst_adr_dat", {22'd0, adr_o, dat_o}, 32'd0);
      exp_w(2'd0, 8'hC0);
      rst_i = 1'b0;

      // 1: write bus0 addr 0x22 data 0xA5
      exp_w(1, 8'h00); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h44);
      exp_w(2, 8'h01); exp_w(1, 8'hA5); exp_w(2, 8'h01); exp_w(2, 8'h05);
      exp_r(2'b00, 8'h00);
      send(1'b0, 4'd0, 7'h22, 8'hA5);
      wait_idle("t1_write");

      // 2: read bus1 addr 0x22 -> 0x3C
      exp_w(1, 8'h01); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h45);
      exp_w(2, 8'h01); exp_w(2, 8'h03); exp_w(2, 8'h05);
      exp_r(2'b00, 8'h3C);
      send(1'b1, 4'd1, 7'h22, 8'h00);
      wait_idle("t2_read");

      // 3: address NAK on write, stop still issued, then a good write
      exp_w(1, 8'h02); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h20);
      exp_w(2, 8'h01); exp_w(2, 8'h05);
      exp_r(2'b01, 8'h00);
      send(1'b0, 4'd2, 7'h10, 8'h77);
      wait_idle("t3_nak");
      exp_w(1, 8'h03); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h44);
      exp_w(2, 8'h01); exp_w(1, 8'h5A); exp_w(2, 8'h01); exp_w(2, 8'h05);
      exp_r(2'b00, 8'h00);
      send(1'b0, 4'd3, 7'h22, 8'h5A);
      wait_idle("t3_after_nak");

      // read with address NAK: data must be 0x00
      exp_w(1, 8'h04); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h21);
      exp_w(2, 8'h01); exp_w(2, 8'h05);
      exp_r(2'b01, 8'h00);
      send(1'b1, 4'd4, 7'h10, 8'h00);
      wait_idle("t3_read_nak");

      // 4: last valid bus, then out-of-range bus -> ERR without stop
      exp_w(1, 8'h0B); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h44);
      exp_w(2, 8'h01); exp_w(1, 8'h11); exp_w(2, 8'h01); exp_w(2, 8'h05);
      exp_r(2'b00, 8'h00);
      send(1'b0, 4'd11, 7'h22, 8'h11);
      wait_idle("t4_last_bus");
      exp_w(1, 8'h0C); exp_w(2, 8'h06);
      exp_r(2'b11, 8'h00);
      send(1'b0, 4'd12, 7'h22, 8'h11);
      wait_idle("t4_bad_bus");

      // arbitration lost on start -> status 10, no stop
      force_al = 1'b1;
      exp_w(1, 8'h00); exp_w(2, 8'h06); exp_w(2, 8'h04);
      exp_r(2'b10, 8'h00);
      send(1'b0, 4'd0, 7'h22, 8'h33);
      wait_idle("t_al");
      force_al = 1'b0;

      // 5: irq never arrives -> timeout status 11
      irq_kill = 1'b1;
      exp_w(1, 8'h00); exp_w(2, 8'h06);
      exp_r(2'b11, 8'h00);
      send(1'b0, 4'd0, 7'h22, 8'h12);
      n = 0;
      while (!rsp_valid_o && n < 1000) begin
         @(negedge clk_i);
         n++;
      end
      diff = cyc_cnt - last_cmdr_cyc;
      total++;
      if (!rsp_valid_o || diff < TO + 1 || diff > TO + 3) begin
         bad++;
         $display("FAIL timeout_lat: got %0d cycles expected %0d..%0d", diff, TO + 1, TO + 3);
      end
      wait_idle("t5_timeout");
      irq_kill = 1'b0;

      // 6: reset during data-byte wait
      base = data_cmd_cnt;
      exp_w(1, 8'h05); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h44);
      exp_w(2, 8'h01); exp_w(1, 8'h99); exp_w(2, 8'h01);
      send(1'b0, 4'd5, 7'h22, 8'h99);
      n = 0;
      while (data_cmd_cnt == base && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      check("t6_reached_data_wait", 32'(data_cmd_cnt - base), 32'd1);
      @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("t6_rst_cyc", 32'(cyc_o), 32'd0);
      check("t6_rst_ready", 32'(req_ready_o), 32'd0);
      check("t6_wb_consumed", 32'(exp_wb.size()), 32'd0);
      repeat (3) @(negedge clk_i);
      exp_w(0, 8'hC0);
      rst_i = 1'b0;
      wait_idle("t6_reenable");

      // recovery: read after reset
      exp_w(1, 8'h00); exp_w(2, 8'h06); exp_w(2, 8'h04); exp_w(1, 8'h45);
      exp_w(2, 8'h01); exp_w(2, 8'h03); exp_w(2, 8'h05);
      exp_r(2'b00, 8'h3C);
      send(1'b1, 4'd0, 7'h22, 8'h00);
      wait_idle("t6_recover");
      check("final_rsp_data_held", {22'd0, rsp_status_o, rsp_data_o}, {22'd0, 2'b00, 8'h3C});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
